// File: rtl/shift_unit_seq_if.sv
// Request/result handshake bundle for the sequential shifter.
// Optional carry_out member is present only when SHIFT_CARRY_OUT_EN is defined.
interface shift_unit_seq_if #(
    parameter int DATA_WIDTH  = 20,
    parameter int SHIFT_WIDTH = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  data_in;
    logic [SHIFT_WIDTH-1:0] shift_amount;
    logic [1:0]             mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  data_out;
`ifdef SHIFT_CARRY_OUT_EN
    logic                   carry_out;
`endif

`ifdef SHIFT_CARRY_OUT_EN
    modport slave (
        input  in_valid, data_in, shift_amount, mode, out_ready,
        output in_ready, out_valid, data_out, carry_out
    );
    modport master (
        output in_valid, data_in, shift_amount, mode, out_ready,
        input  in_ready, out_valid, data_out, carry_out
    );
`else
    modport slave (
        input  in_valid, data_in, shift_amount, mode, out_ready,
        output in_ready, out_valid, data_out
    );
    modport master (
        output in_valid, data_in, shift_amount, mode, out_ready,
        input  in_ready, out_valid, data_out
    );
`endif
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle SLL/SRL/SRA/ROL shifter advancing up to STEP bits per clock.
// Define SHIFT_CARRY_OUT_EN to add the carry_out result (last bit shifted out).
module shift_unit_seq #(
    parameter int DATA_WIDTH  = 20,
    parameter int SHIFT_WIDTH = 5,
    parameter int STEP        = 4
) (
    input logic            clk,
    input logic            rst_n,
    shift_unit_seq_if.slave bus
);
    localparam int DW_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int CNT_W    = (SHIFT_WIDTH > DW_CNT_W) ? SHIFT_WIDTH : DW_CNT_W;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    state_e                state_q;
    mode_e                 mode_q;
    logic [DATA_WIDTH-1:0] dataOut_q;
    logic [CNT_W-1:0]      remain_q;
    logic                  inReady_q;
    logic                  outValid_q;

    logic [CNT_W-1:0]      amtExt_d;
    logic [CNT_W-1:0]      effCount_d;
    logic [CNT_W-1:0]      stepCnt_d;
    logic [DATA_WIDTH-1:0] shifted_d;

`ifdef SHIFT_CARRY_OUT_EN
    localparam logic [DATA_WIDTH-1:0] LSB_ONE = DATA_WIDTH'(1);
    logic carry_q;
    logic overshift_q;
    logic carryBit_d;
`endif

    // Rotates keep the raw count and simply wrap; linear shifts saturate at the width.
    always_comb begin
        amtExt_d   = CNT_W'(bus.shift_amount);
        effCount_d = amtExt_d;
        if ((mode_e'(bus.mode) != MODE_ROL) && (amtExt_d > CNT_W'(DATA_WIDTH))) begin
            effCount_d = CNT_W'(DATA_WIDTH);
        end
    end

    always_comb begin
        stepCnt_d = (remain_q > CNT_W'(STEP)) ? CNT_W'(STEP) : remain_q;
        shifted_d = dataOut_q;
        case (mode_q)
            MODE_SLL: shifted_d = dataOut_q << stepCnt_d;
            MODE_SRL: shifted_d = dataOut_q >> stepCnt_d;
            MODE_SRA: shifted_d = $unsigned($signed(dataOut_q) >>> stepCnt_d);
            MODE_ROL: shifted_d = (dataOut_q << stepCnt_d)
                                | (dataOut_q >> (CNT_W'(DATA_WIDTH) - stepCnt_d));
            default:  shifted_d = dataOut_q;
        endcase
    end

`ifdef SHIFT_CARRY_OUT_EN
    // Bit leaving the word this step; overshifted SLL/SRL report 0 rather than a real bit.
    always_comb begin
        carryBit_d = 1'b0;
        case (mode_q)
            MODE_SLL: carryBit_d = |(dataOut_q & (LSB_ONE << (CNT_W'(DATA_WIDTH) - stepCnt_d)));
            MODE_SRL,
            MODE_SRA: carryBit_d = |(dataOut_q & (LSB_ONE << (stepCnt_d - CNT_W'(1))));
            MODE_ROL: carryBit_d = shifted_d[0];
            default:  carryBit_d = 1'b0;
        endcase
        if (overshift_q && ((mode_q == MODE_SLL) || (mode_q == MODE_SRL))) begin
            carryBit_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_SLL;
            dataOut_q  <= '0;
            remain_q   <= '0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
`ifdef SHIFT_CARRY_OUT_EN
            carry_q     <= 1'b0;
            overshift_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        dataOut_q <= bus.data_in;
                        mode_q    <= mode_e'(bus.mode);
                        remain_q  <= effCount_d;
                        inReady_q <= 1'b0;
`ifdef SHIFT_CARRY_OUT_EN
                        carry_q     <= 1'b0;
                        overshift_q <= (amtExt_d > CNT_W'(DATA_WIDTH));
`endif
                        if (effCount_d == '0) begin
                            state_q    <= DONE;
                            outValid_q <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    dataOut_q <= shifted_d;
                    remain_q  <= remain_q - stepCnt_d;
`ifdef SHIFT_CARRY_OUT_EN
                    carry_q <= carryBit_d;
`endif
                    if (remain_q == stepCnt_d) begin
                        state_q    <= DONE;
                        outValid_q <= 1'b1;
                    end
                end
                // The consumed cycle only returns to IDLE, so accepts never overlap a handoff.
                DONE: begin
                    if (bus.out_ready) begin
                        state_q    <= IDLE;
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.out_valid = outValid_q;
    assign bus.data_out  = dataOut_q;
`ifdef SHIFT_CARRY_OUT_EN
    assign bus.carry_out = carry_q;
`endif

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: directed requests push expectations, a monitor checks results.
// Carry checks are included when SHIFT_CARRY_OUT_EN is defined.
module tb_shift_unit_seq;
    localparam int DW = 20;
    localparam int SW = 5;
    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] ROL = 2'b11;

    typedef struct {
        logic [DW-1:0] data;
        logic          carry;
        int            due;
    } expect_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cycleCnt = 0;
    int   checkCount = 0;
    int   missCount = 0;
    expect_t scoreQ[$];

    shift_unit_seq_if #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW)) bus ();

    shift_unit_seq #(.DATA_WIDTH(DW), .SHIFT_WIDTH(SW), .STEP(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each rising out_valid pops one expectation and checks value, timing and carry.
    bit seenValid = 1'b0;
    always @(negedge clk) begin
        expect_t e;
        if (bus.out_valid === 1'b1 && !seenValid) begin
            seenValid = 1'b1;
            if (scoreQ.size() == 0) begin
                checkCount++;
                missCount++;
                $display("[TB] FAIL unexpected result: got data 0x%0h, want no result", bus.data_out);
            end else begin
                e = scoreQ.pop_front();
                checkOutput("data_out", 32'(bus.data_out), 32'(e.data));
                checkOutput("out_valid cycle", cycleCnt, e.due);
`ifdef SHIFT_CARRY_OUT_EN
                checkOutput("carry_out", 32'(bus.carry_out), 32'(e.carry));
`endif
            end
        end else if (bus.out_valid !== 1'b1) begin
            seenValid = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] d, input logic [SW-1:0] amt,
                                 input logic [1:0] m, input logic [DW-1:0] expD,
                                 input logic expCarry, input int expC, input bit track);
        int waitCnt = 0;
        @(negedge clk);
        bus.data_in      = d;
        bus.shift_amount = amt;
        bus.mode         = m;
        bus.in_valid     = 1'b1;
        while (bus.in_ready !== 1'b1 && waitCnt < 200) begin
            @(negedge clk);
            waitCnt++;
        end
        if (bus.in_ready !== 1'b1) begin
            checkOutput("in_ready timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        if (track) scoreQ.push_back('{expD, expCarry, cycleCnt + 1 + expC});
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int waitCnt;
        rst_n            = 1'b0;
        bus.in_valid     = 1'b0;
        bus.data_in      = '0;
        bus.shift_amount = '0;
        bus.mode         = SLL;
        bus.out_ready    = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset data_out", 32'(bus.data_out), 32'd0);
        rst_n = 1'b1;

        // Directed vectors: data, amount, mode, expected data, expected carry, cycles C.
        applyStimulus(20'hAAAAA,  5'd3, SLL, 20'h55550, 1'b1, 1, 1'b1);
        applyStimulus(20'h8A8AA,  5'd7, SRA, 20'hFF151, 1'b0, 2, 1'b1);
        applyStimulus(20'h8A8AA,  5'd7, SRL, 20'h01151, 1'b0, 2, 1'b1);
        applyStimulus(20'h80001,  5'd1, ROL, 20'h00003, 1'b1, 1, 1'b1);
        applyStimulus(20'h80001, 5'd21, ROL, 20'h00003, 1'b1, 6, 1'b1);
        applyStimulus(20'hFFFFF, 5'd31, SLL, 20'h00000, 1'b0, 5, 1'b1);
        applyStimulus(20'h12345,  5'd0, SRL, 20'h12345, 1'b0, 0, 1'b1);
        applyStimulus(20'h80000, 5'd25, SRA, 20'hFFFFF, 1'b1, 5, 1'b1);
        applyStimulus(20'hFFFFF, 5'd20, SRL, 20'h00000, 1'b1, 5, 1'b1);
        applyStimulus(20'h00001, 5'd20, SLL, 20'h00000, 1'b1, 5, 1'b1);
        applyStimulus(20'h12345,  5'd4, ROL, 20'h23451, 1'b1, 1, 1'b1);
        applyStimulus(20'h12345, 5'd20, ROL, 20'h12345, 1'b1, 5, 1'b1);
        applyStimulus(20'h12345,  5'd5, SRL, 20'h0091A, 1'b0, 2, 1'b1);

        // Backpressure: result must hold while in_valid pulses are ignored.
        waitCnt = 0;
        while (bus.in_ready !== 1'b1 && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        bus.out_ready = 1'b0;
        applyStimulus(20'h0000F, 5'd2, SLL, 20'h0003C, 1'b0, 1, 1'b1);
        waitCnt = 0;
        while (bus.out_valid !== 1'b1 && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("backpressure out_valid rise", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid     = i[0];
            bus.data_in      = 20'h55555;
            bus.shift_amount = 5'd1;
            @(negedge clk);
            checkOutput("hold data_out", 32'(bus.data_out), 32'h0003C);
            checkOutput("hold out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("release out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("release data_out kept", 32'(bus.data_out), 32'h0003C);

        // Mid-operation reset discards the rotate in flight.
        applyStimulus(20'h80001, 5'd20, ROL, 20'h80001, 1'b1, 5, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midreset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midreset data_out", 32'(bus.data_out), 32'd0);
        checkOutput("midreset in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(20'h80001, 5'd1, ROL, 20'h00003, 1'b1, 1, 1'b1);

        waitCnt = 0;
        while (scoreQ.size() != 0 && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("scoreboard drained", scoreQ.size(), 32'd0);
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
        $finish;
    end
endmodule
